// File: rtl/taxi_xgmii_rx_link_ctrl.sv
// taxi_xgmii_rx_link_ctrl: XGMII RX link-fault supervisor, RX enable hold-off sequencer and status counters.
// Watches the RX column tap for local/remote fault ordered sets and runs the RS link-fault state machine.
module taxi_xgmii_rx_link_ctrl #(
  parameter int DATA_W         = 32,
  parameter int CTRL_W         = DATA_W/8,
  parameter int FAULT_WINDOW   = 128,
  parameter int FAULT_SEQ_CNT  = 4,
  parameter int HOLDOFF_CYCLES = 1024,
  parameter int STAT_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] xgmii_rxd,
  input  logic [CTRL_W-1:0] xgmii_rxc,
  input  logic              cfg_rx_enable_req,
  output logic              cfg_rx_enable,
  input  logic              start_packet,
  input  logic              error_bad_frame,
  input  logic              error_bad_fcs,
  input  logic              stat_clear,
  output logic [1:0]        link_status,
  output logic              tx_send_remote_fault,
  output logic              tx_send_idle,
  output logic [STAT_W-1:0] stat_rx_frames,
  output logic [STAT_W-1:0] stat_rx_bad_frame,
  output logic [STAT_W-1:0] stat_rx_bad_fcs,
  output logic [STAT_W-1:0] stat_fault_events
);
  typedef enum logic [1:0] {OK = 2'd0, LOCAL = 2'd1, REMOTE = 2'd2} link_t;
  localparam int CW = $clog2(FAULT_WINDOW + 1);
  localparam int SW = $clog2(FAULT_SEQ_CNT + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  link_t link_q, link_d, last_q, last_d, col_type;
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [SW-1:0] seq_cnt_q, seq_cnt_d;
  logic [HW-1:0] holdoff_q, holdoff_d;
  logic en_q, en_d, tx_rf_q, tx_rf_d, tx_idle_q, tx_idle_d, fault, expire, enter;
  logic [STAT_W-1:0] frames_q, frames_d, bad_frame_q, bad_frame_d, bad_fcs_q, bad_fcs_d, events_q, events_d;

  function automatic logic [STAT_W-1:0] bump(input logic [STAT_W-1:0] c, input logic s, input logic clr);
    return clr ? STAT_W'(s) : (s && !(&c)) ? c + STAT_W'(1) : c;
  endfunction

  // last_q uses OK as the "no sequence seen" marker
  always_comb begin
    col_type    = (xgmii_rxc == CTRL_W'(1) && xgmii_rxd == DATA_W'(32'h0100009C)) ? LOCAL :
                  (xgmii_rxc == CTRL_W'(1) && xgmii_rxd == DATA_W'(32'h0200009C)) ? REMOTE : OK;
    fault       = col_type != OK;
    expire      = !fault && col_cnt_q == CW'(FAULT_WINDOW - 1);
    col_cnt_d   = fault ? '0 : (col_cnt_q == CW'(FAULT_WINDOW)) ? col_cnt_q : col_cnt_q + CW'(1);
    last_d      = fault ? col_type : expire ? OK : last_q;
    seq_cnt_d   = !fault ? (expire ? '0 : seq_cnt_q) :
                  (col_type != last_q) ? SW'(1) :
                  (seq_cnt_q == SW'(FAULT_SEQ_CNT)) ? seq_cnt_q : seq_cnt_q + SW'(1);
    enter       = fault && seq_cnt_d == SW'(FAULT_SEQ_CNT) && col_type != link_q;
    link_d      = enter ? col_type : expire ? OK : link_q;
    tx_rf_d     = link_d == LOCAL;
    tx_idle_d   = link_d == REMOTE;
    holdoff_d   = (link_q != OK) ? HW'(HOLDOFF_CYCLES) : holdoff_q - HW'(holdoff_q != '0);
    en_d        = cfg_rx_enable_req && link_d == OK && holdoff_q == '0;
    frames_d    = bump(frames_q, start_packet, stat_clear);
    bad_frame_d = bump(bad_frame_q, error_bad_frame, stat_clear);
    bad_fcs_d   = bump(bad_fcs_q, error_bad_fcs, stat_clear);
    events_d    = bump(events_q, enter, stat_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q      <= OK;
      last_q      <= OK;
      col_cnt_q   <= '0;
      seq_cnt_q   <= '0;
      holdoff_q   <= HW'(HOLDOFF_CYCLES);
      en_q        <= 1'b0;
      tx_rf_q     <= 1'b0;
      tx_idle_q   <= 1'b0;
      frames_q    <= '0;
      bad_frame_q <= '0;
      bad_fcs_q   <= '0;
      events_q    <= '0;
    end else begin
      link_q      <= link_d;
      last_q      <= last_d;
      col_cnt_q   <= col_cnt_d;
      seq_cnt_q   <= seq_cnt_d;
      holdoff_q   <= holdoff_d;
      en_q        <= en_d;
      tx_rf_q     <= tx_rf_d;
      tx_idle_q   <= tx_idle_d;
      frames_q    <= frames_d;
      bad_frame_q <= bad_frame_d;
      bad_fcs_q   <= bad_fcs_d;
      events_q    <= events_d;
    end
  end

  assign link_status          = link_q;
  assign cfg_rx_enable        = en_q;
  assign tx_send_remote_fault = tx_rf_q;
  assign tx_send_idle         = tx_idle_q;
  assign stat_rx_frames       = frames_q;
  assign stat_rx_bad_frame    = bad_frame_q;
  assign stat_rx_bad_fcs      = bad_fcs_q;
  assign stat_fault_events    = events_q;
endmodule

// File: tb/tb_taxi_xgmii_rx_link_ctrl.sv
// tb_taxi_xgmii_rx_link_ctrl: scenario tasks plus randomized traffic against a queue-based link-fault model.
module tb_taxi_xgmii_rx_link_ctrl;
  localparam int W = 128, N = 4, H = 1024, SW = 8, SMAX = 255;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [31:0] rxd = 32'h07070707;
  logic [3:0] rxc = 4'hF;
  logic req = 1'b0, sp = 1'b0, bf = 1'b0, bfcs = 1'b0, clr = 1'b0;
  logic en, tx_rf, tx_idle;
  logic [1:0] link;
  logic [SW-1:0] s_fr, s_bf, s_bfcs, s_ev;
  int checks = 0, failures = 0;
  int m_link, m_age, m_gap, m_fr, m_bf, m_bfcs, m_ev;
  bit m_en;
  int fq[$];

  always #5 clk = ~clk;

  taxi_xgmii_rx_link_ctrl #(.STAT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .xgmii_rxd(rxd), .xgmii_rxc(rxc),
    .cfg_rx_enable_req(req), .cfg_rx_enable(en),
    .start_packet(sp), .error_bad_frame(bf), .error_bad_fcs(bfcs), .stat_clear(clr),
    .link_status(link), .tx_send_remote_fault(tx_rf), .tx_send_idle(tx_idle),
    .stat_rx_frames(s_fr), .stat_rx_bad_frame(s_bf), .stat_rx_bad_fcs(s_bfcs), .stat_fault_events(s_ev)
  );

  function automatic int sat(int v);
    return v > SMAX ? SMAX : v;
  endfunction

  task automatic set_col(int t);
    rxc = (t == 0) ? 4'hF : 4'h1;
    rxd = (t == 0) ? 32'h07070707 : (t == 1) ? 32'h0100009C : 32'h0200009C;
  endtask

  task automatic model_reset();
    m_link = 0; m_age = 0; m_gap = 0; m_en = 0;
    m_fr = 0; m_bf = 0; m_bfcs = 0; m_ev = 0;
    fq.delete();
  endtask

  // Fault history is a queue of sequence types since the last quiet window; the run length is its same-type tail.
  task automatic model_edge();
    int t, run, old;
    bit entered;
    old = m_link;
    entered = 0;
    t = (rxc == 4'h1 && rxd == 32'h0100009C) ? 1 : (rxc == 4'h1 && rxd == 32'h0200009C) ? 2 : 0;
    if (t != 0) begin
      m_gap = 0;
      fq.push_back(t);
      run = 0;
      for (int i = fq.size() - 1; i >= 0 && fq[i] == t; i--) run++;
      if (run >= N && t != m_link) begin m_link = t; entered = 1; end
    end else begin
      m_gap++;
      if (m_gap == W) begin fq.delete(); m_link = 0; end
    end
    m_en = req && m_link == 0 && m_age >= H;
    m_age = (old == 0) ? m_age + 1 : 0;
    m_fr   = clr ? int'(sp)      : sat(m_fr + int'(sp));
    m_bf   = clr ? int'(bf)      : sat(m_bf + int'(bf));
    m_bfcs = clr ? int'(bfcs)    : sat(m_bfcs + int'(bfcs));
    m_ev   = clr ? int'(entered) : sat(m_ev + int'(entered));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    req = 1'b1; set_col(0);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({link, tx_rf, tx_idle, en} !== 5'b0) begin
      failures++; $display("FAIL reset_outputs link=%0d txrf=%b txidle=%b en=%b want 0", link, tx_rf, tx_idle, en);
    end
    checks++;
    if ({s_fr, s_bf, s_bfcs, s_ev} !== '0) begin
      failures++; $display("FAIL reset_counters fr=%0d bf=%0d fcs=%0d ev=%0d want 0", s_fr, s_bf, s_bfcs, s_ev);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_holdoff();
    int rise = -1;
    for (int k = 1; k <= H + 4; k++) begin
      tick();
      checks++;
      if (en !== m_en || link !== 2'd0) begin
        failures++; $display("FAIL holdoff_track cyc=%0d en=%b want %b link=%0d want 0", k, en, m_en, link);
      end
      if (en === 1'b1 && rise < 0) rise = k;
    end
    checks++;
    if (rise != H + 1) begin failures++; $display("FAIL holdoff_rise got=%0d want %0d", rise, H + 1); end
  endtask

  task automatic test_local_fault();
    int rise = -1;
    for (int i = 0; i < 4; i++) begin
      set_col(1); tick();
      if (i < 3) begin set_col(0); repeat (10) tick(); end
    end
    checks++;
    if (link !== 2'd1) begin failures++; $display("FAIL lf_enter link=%0d want 1", link); end
    checks++;
    if (en !== 1'b0 || tx_rf !== 1'b1 || tx_idle !== 1'b0) begin
      failures++; $display("FAIL lf_outputs en=%b txrf=%b txidle=%b want 0 1 0", en, tx_rf, tx_idle);
    end
    checks++;
    if (s_ev !== 8'd1 || int'(s_ev) != m_ev) begin failures++; $display("FAIL lf_events got=%0d want 1", s_ev); end
    set_col(0);
    for (int k = 1; k <= W; k++) begin
      tick();
      checks++;
      if (link !== ((k == W) ? 2'd0 : 2'd1) || int'(link) != m_link || en !== 1'b0) begin
        failures++; $display("FAIL lf_recover idle=%0d link=%0d want %0d en=%b", k, link, (k == W) ? 0 : 1, en);
      end
    end
    for (int k = 1; k <= H + 4; k++) begin
      tick();
      checks++;
      if (en !== m_en) begin failures++; $display("FAIL lf_reholdoff cyc=%0d en=%b want %b", k, en, m_en); end
      if (en === 1'b1 && rise < 0) rise = k;
    end
    checks++;
    if (rise != H + 1) begin failures++; $display("FAIL lf_reenable got=%0d want %0d", rise, H + 1); end
  endtask

  task automatic test_window_expiry();
    set_col(1); repeat (3) tick();
    set_col(0); repeat (W) tick();
    set_col(1); tick();
    set_col(0);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (link !== 2'd0 || m_link != 0 || en !== 1'b1) begin
        failures++; $display("FAIL window_expiry cyc=%0d link=%0d want 0 en=%b want 1", k, link, en);
      end
      tick();
    end
  endtask

  task automatic test_switch();
    clr = 1'b1; tick(); clr = 1'b0;
    set_col(1); repeat (4) tick();
    checks++;
    if (link !== 2'd1 || s_ev !== 8'd1) begin failures++; $display("FAIL sw_local link=%0d ev=%0d want 1 1", link, s_ev); end
    for (int i = 0; i < 4; i++) begin
      set_col((i % 2) + 1); tick();
      set_col(0); tick();
      checks++;
      if (link !== 2'd1 || m_link != 1) begin failures++; $display("FAIL sw_alternate step=%0d link=%0d want 1", i, link); end
    end
    set_col(2); repeat (4) tick();
    checks++;
    if (link !== 2'd2 || tx_idle !== 1'b1 || tx_rf !== 1'b0) begin
      failures++; $display("FAIL sw_remote link=%0d txidle=%b txrf=%b want 2 1 0", link, tx_idle, tx_rf);
    end
    checks++;
    if (s_ev !== 8'd2 || int'(s_ev) != m_ev) begin failures++; $display("FAIL sw_events got=%0d want 2", s_ev); end
    set_col(0); repeat (W) tick();
    checks++;
    if (link !== 2'd0) begin failures++; $display("FAIL sw_recover link=%0d want 0", link); end
  endtask

  task automatic test_ctrl_alias();
    rxc = 4'b0011; rxd = 32'h0100009C;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (link !== 2'd0 || m_link != 0) begin failures++; $display("FAIL ctrl_alias cyc=%0d link=%0d want 0", k, link); end
    end
    set_col(0);
  endtask

  task automatic test_counters();
    clr = 1'b1; tick(); clr = 1'b0;
    for (int k = 0; k < 260; k++) begin
      bfcs = 1'b1; sp = 1'($urandom); bf = 1'($urandom);
      tick();
      checks++;
      if (int'(s_fr) != m_fr || int'(s_bf) != m_bf || int'(s_bfcs) != m_bfcs) begin
        failures++; $display("FAIL cnt_track cyc=%0d fr=%0d/%0d bf=%0d/%0d fcs=%0d/%0d", k, s_fr, m_fr, s_bf, m_bf, s_bfcs, m_bfcs);
      end
    end
    bf = 1'b0; sp = 1'b0; tick();
    checks++;
    if (s_bfcs !== 8'hFF) begin failures++; $display("FAIL cnt_saturate got=%0d want 255", s_bfcs); end
    bfcs = 1'b0; clr = 1'b1; sp = 1'b1; tick();
    checks++;
    if (s_fr !== 8'd1 || s_bfcs !== 8'd0 || s_bf !== 8'd0) begin
      failures++; $display("FAIL cnt_clear_strobe fr=%0d fcs=%0d bf=%0d want 1 0 0", s_fr, s_bfcs, s_bf);
    end
    sp = 1'b0; tick(); clr = 1'b0;
    checks++;
    if (s_fr !== 8'd0) begin failures++; $display("FAIL cnt_clear got=%0d want 0", s_fr); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 40; s++) begin
      int t, n;
      t = $urandom_range(1, 2);
      n = $urandom_range(1, 6);
      for (int j = 0; j < n + 1; j++) begin
        int gap;
        gap = (j == n) ? $urandom_range(0, 160) : $urandom_range(0, 3);
        for (int c = 0; c <= gap; c++) begin
          set_col((c == 0 && j < n) ? t : 0);
          sp = 1'($urandom_range(0, 3) == 0); bf = 1'($urandom); bfcs = 1'($urandom);
          clr = 1'($urandom_range(0, 199) == 0);
          if ($urandom_range(0, 299) == 0) req = ~req;
          tick();
          checks++;
          if ({link, tx_rf, tx_idle, en} !== {m_link[1:0], m_link == 1, m_link == 2, m_en}) begin
            failures++; $display("FAIL rand_link seg=%0d link=%0d/%0d txrf=%b txidle=%b en=%b/%b", s, link, m_link, tx_rf, tx_idle, en, m_en);
          end
          checks++;
          if (int'(s_fr) != m_fr || int'(s_bf) != m_bf || int'(s_bfcs) != m_bfcs || int'(s_ev) != m_ev) begin
            failures++; $display("FAIL rand_cnt seg=%0d fr=%0d/%0d bf=%0d/%0d fcs=%0d/%0d ev=%0d/%0d", s, s_fr, m_fr, s_bf, m_bf, s_bfcs, m_bfcs, s_ev, m_ev);
          end
        end
      end
    end
    sp = 1'b0; bf = 1'b0; bfcs = 1'b0; clr = 1'b0; req = 1'b1; set_col(0);
  endtask

  task automatic test_async_reset();
    int rise = -1;
    sp = 1'b1; set_col(1); repeat (4) tick(); sp = 1'b0; set_col(0); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({link, tx_rf, tx_idle, en} !== 5'b0 || {s_fr, s_bf, s_bfcs, s_ev} !== '0) begin
      failures++; $display("FAIL async_reset link=%0d txrf=%b en=%b fr=%0d ev=%0d want all 0", link, tx_rf, en, s_fr, s_ev);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= H + 4; k++) begin
      tick();
      if (en === 1'b1 && rise < 0) rise = k;
    end
    checks++;
    if (rise != H + 1) begin failures++; $display("FAIL async_reholdoff got=%0d want %0d", rise, H + 1); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_holdoff();
    test_local_fault();
    test_window_expiry();
    test_switch();
    test_ctrl_alias();
    test_counters();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
